ledpanel_axil_regfile: RTL

- Parametrised AXI4-Lite slave register file; next generation of the fixed four-register ledpanel slave.
- Generalises to NUM_REGS registers with byte strobes, per-register read-only status slots, SLVERR decode and per-register write-strobe pulses.
- Sits between the AXI interconnect and the LED panel scan/timing logic.

---
 rtl/ledpanel_regs_pkg.sv | 8 +
 rtl/ledpanel_reg_cell.sv | 43 ++++
 rtl/ledpanel_axil_regfile.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ledpanel_regs_pkg.sv
// ledpanel_regs_pkg: response codes, FSM state types and lane count shared by the ledpanel register file.
package ledpanel_regs_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int BYTE_LANES = 4;
    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
endpackage

// File: rtl/ledpanel_reg_cell.sv
// ledpanel_reg_cell: one writable register with byte-strobe merge, wr_pulse and optional shadow stage (LEDPANEL_REGS_SHADOW_EN).
module ledpanel_reg_cell
    import ledpanel_regs_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [BYTE_LANES-1:0]     strb,
    input  logic [BYTE_LANES*8-1:0]   wdata,
    input  logic                      frame_sync,
    output logic [BYTE_LANES*8-1:0]   q,
    output logic [BYTE_LANES*8-1:0]   out,
    output logic                      pulse
);
    logic [BYTE_LANES*8-1:0] merged;
    // overlay the strobed bytes of the write data onto the current value
    always_comb begin
        merged = q;
        for (int b = 0; b < BYTE_LANES; b++)
            if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    // live value plus a one-cycle pulse for writes that touch at least one byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            pulse <= 1'b0;
        end else begin
            if (we) q <= merged;
            pulse <= we && |strb;
        end
    end
`ifdef LEDPANEL_REGS_SHADOW_EN
    // panel-facing copy follows the live value only on frame_sync, including a same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= '0;
        else if (frame_sync) out <= we ? merged : q;
    end
`else
    logic unused_fs;
    assign unused_fs = frame_sync;
    assign out = q;
`endif
endmodule

// File: rtl/ledpanel_axil_regfile.sv
// ledpanel_axil_regfile: AXI4-Lite register file for the LED panel; LEDPANEL_REGS_SHADOW_EN stages regs_out behind frame_sync.
module ledpanel_axil_regfile
    import ledpanel_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = 8'h80
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_pulse,
    input  logic                                   frame_sync
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int LW = $clog2(NUM_REGS);
    w_state_t w_state;
    r_state_t r_state;
    logic aw_held, w_held, commit, aw_ok, wr_ok, ar_ok;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [DW-1:0] wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic [DW-1:0] rd_val [NUM_REGS];
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign commit = aw_held && w_held;
    assign aw_ok  = int'(aw_idx) < NUM_REGS;
    assign wr_ok  = aw_ok && !RO_MASK[aw_idx[LW-1:0]];
    assign ar_ok  = int'(ar_idx) < NUM_REGS;
    assign S_AXI_AWREADY = ARESETN && !aw_held && w_state != W_RESP;
    assign S_AXI_WREADY  = ARESETN && !w_held && w_state != W_RESP;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_ARREADY = ARESETN && r_state == R_IDLE;
    assign S_AXI_RVALID  = r_state == R_RESP;

    // write channel: capture AW and W independently, commit once both are held, then hold B until taken
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state     <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            unique case (w_state)
                W_IDLE, W_COLLECT: begin
                    if (commit) begin
                        w_state     <= W_RESP;
                        aw_held     <= 1'b0;
                        w_held      <= 1'b0;
                        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (S_AXI_AWVALID && !aw_held) begin
                            aw_held <= 1'b1;
                            aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        end
                        if (S_AXI_WVALID && !w_held) begin
                            w_held  <= 1'b1;
                            wdata_q <= S_AXI_WDATA;
                            wstrb_q <= S_AXI_WSTRB;
                        end
                        w_state <= (aw_held || w_held || S_AXI_AWVALID || S_AXI_WVALID) ? W_COLLECT : W_IDLE;
                    end
                end
                W_RESP: if (S_AXI_BREADY) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // read channel: register data and response at the AR handshake, hold until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= R_IDLE;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: if (S_AXI_ARVALID) begin
                    r_state     <= R_RESP;
                    S_AXI_RDATA <= ar_ok ? rd_val[ar_idx[LW-1:0]] : '0;
                    S_AXI_RRESP <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                end
                R_RESP: if (S_AXI_RREADY) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign rd_val[i] = status_in[DW*i +: DW];
            assign regs_out[DW*i +: DW] = '0;
            assign wr_pulse[i] = 1'b0;
        end else begin : g_rw
            logic unused_status;
            assign unused_status = ^status_in[DW*i +: DW];
            ledpanel_reg_cell u_cell (
                .clk       (ACLK),
                .rst_n     (ARESETN),
                .we        (commit && wr_ok && aw_idx == IW'(i)),
                .strb      (wstrb_q),
                .wdata     (wdata_q),
                .frame_sync(frame_sync),
                .q         (rd_val[i]),
                .out       (regs_out[DW*i +: DW]),
                .pulse     (wr_pulse[i])
            );
        end
    end
endmodule
